// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register bank: clear-sequencer state
// encoding and packed-port slicing helpers.
package regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clear_state_t;

    localparam int WRITE_PORTS = 2;

    // Low bit of port `port` inside a packed bus of `width`-bit fields.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every entry writing zero after reset or on request,
// then raises ready and hands the file over to normal operation.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear_request,
    output logic                  clear_we,
    output logic [ADDR_WIDTH-1:0] clear_addr,
    output logic                  ready
);

    clear_state_t          state;
    logic [ADDR_WIDTH-1:0] count;

    // No clear write on a reset edge; the first one lands on the first edge after.
    assign clear_we   = (state == ST_CLEAR) && !reset;
    assign clear_addr = count;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_CLEAR;
            count <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    count <= count + 1'b1;
                    if (&count) begin
                        state <= ST_READY;
                        ready <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (clear_request) begin
                        state <= ST_CLEAR;
                        count <= '0;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                    count <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/register_bank_mp.sv
// Multi-port register bank: READ_PORTS combinational reads, two synchronous
// write ports, optional hardwired-zero entry 0 and write-to-read bypass.
// Writes are accepted only while ready=1; there is no backpressure otherwise.
module register_bank_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               clear_request,
    input  logic [WRITE_PORTS-1:0]             write_enable,
    input  logic [WRITE_PORTS*ADDR_WIDTH-1:0]  write_address,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0]  write_data,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0]   read_address,
    output logic [READ_PORTS*DATA_WIDTH-1:0]   read_data,
    output logic                               ready
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam bit HAS_ZERO  = (ZERO_REG != 0);
    localparam bit HAS_BYPASS = (BYPASS != 0);

    logic                  clear_we;
    logic [ADDR_WIDTH-1:0] clear_addr;
    logic                  write_ok;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    regfile_clear_seq #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_clear_seq (
        .clock        (clock),
        .reset        (reset),
        .clear_request(clear_request),
        .clear_we     (clear_we),
        .clear_addr   (clear_addr),
        .ready        (ready)
    );

    assign write_ok = ready && !reset;

    // Priority clear > port 1 > port 0: the ascending loop lets port 1 overwrite port 0.
    always_ff @(posedge clock) begin
        if (clear_we) begin
            mem[clear_addr] <= '0;
        end else if (write_ok) begin
            for (int k = 0; k < WRITE_PORTS; k++) begin
                if (write_enable[k] &&
                    !(HAS_ZERO && (write_address[slice_lo(k, ADDR_WIDTH) +: ADDR_WIDTH] == '0))) begin
                    mem[write_address[slice_lo(k, ADDR_WIDTH) +: ADDR_WIDTH]] <=
                        write_data[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH];
                end
            end
        end
    end

    for (genvar r = 0; r < READ_PORTS; r++) begin : g_read
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd;

        assign ra = read_address[r*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd = mem[ra];
            if (HAS_BYPASS) begin
                for (int k = 0; k < WRITE_PORTS; k++) begin
                    if (write_enable[k] &&
                        (write_address[slice_lo(k, ADDR_WIDTH) +: ADDR_WIDTH] == ra)) begin
                        rd = write_data[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH];
                    end
                end
            end
            if (HAS_ZERO && (ra == '0)) begin
                rd = '0;
            end
            if (!ready) begin
                rd = '0;
            end
        end

        assign read_data[r*DATA_WIDTH +: DATA_WIDTH] = rd;
    end

endmodule

// File: tb/tb_register_bank_mp.sv
// Bench for register_bank_mp (default parameters): directed scenarios plus
// randomized traffic checked against an abstract register-file model.
module tb_register_bank_mp;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int DEPTH = 32;
  localparam int CLEAR_CYCLES = 32;

  logic            clock;
  logic            reset;
  logic            clear_request;
  logic [1:0]      write_enable;
  logic [2*AW-1:0] write_address;
  logic [2*DW-1:0] write_data;
  logic [2*AW-1:0] read_address;
  logic [2*DW-1:0] read_data;
  logic            ready;

  int tests_run;
  int tests_failed;

  // abstract model: contents plus number of clear cycles still to go
  logic [DW-1:0] mem_m [DEPTH];
  int            clear_left;

  register_bank_mp dut (
    .clock        (clock),
    .reset        (reset),
    .clear_request(clear_request),
    .write_enable (write_enable),
    .write_address(write_address),
    .write_data   (write_data),
    .read_address (read_address),
    .read_data    (read_data),
    .ready        (ready)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (clear_left > 0) return '0;
    if (a == 0) return '0;
    v = mem_m[a];
    if (write_enable[0] && write_address[0 +: AW] == a) v = write_data[0 +: DW];
    if (write_enable[1] && write_address[AW +: AW] == a) v = write_data[DW +: DW];
    return v;
  endfunction

  function automatic void model_zero();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endfunction

  // advance one clock and apply the file's rules to the model
  task automatic tick();
    @(posedge clock);
    if (reset) begin
      clear_left = CLEAR_CYCLES;
      model_zero();
    end else if (clear_left > 0) begin
      clear_left--;
    end else begin
      for (int k = 0; k < 2; k++)
        if (write_enable[k] && write_address[k*AW +: AW] != 0)
          mem_m[write_address[k*AW +: AW]] = write_data[k*DW +: DW];
      if (clear_request) begin
        clear_left = CLEAR_CYCLES;
        model_zero();
      end
    end
    #1;
  endtask

  // driver tasks
  task automatic idle();
    clear_request = 1'b0;
    write_enable  = '0;
    write_address = '0;
    write_data    = '0;
  endtask

  task automatic set_wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    write_enable[k]          = 1'b1;
    write_address[k*AW +: AW] = a;
    write_data[k*DW +: DW]    = d;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    read_address = {a1, a0};
  endtask

  task automatic check_ports(input string tag);
    #1;
    chk({tag, "_ready"}, {63'd0, ready}, {63'd0, clear_left == 0});
    chk({tag, "_rd0"}, read_data[0 +: DW], model_read(read_address[0 +: AW]));
    chk({tag, "_rd1"}, read_data[DW +: DW], model_read(read_address[AW +: AW]));
  endtask

  task automatic check_all(input string tag);
    idle();
    for (int i = 0; i < DEPTH; i += 2) begin
      set_rd(i[AW-1:0], i[AW-1:0] + 5'd1);
      check_ports(tag);
    end
  endtask

  task automatic random_cycle();
    idle();
    for (int k = 0; k < 2; k++)
      if ($urandom_range(0, 2) != 0)
        set_wr(k, $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31),
               {$urandom, $urandom});
    set_rd($urandom_range(0, 1) ? write_address[0 +: AW] : $urandom_range(0, 31),
           $urandom_range(0, 1) ? write_address[AW +: AW] : $urandom_range(0, 31));
    clear_request = ($urandom_range(0, 79) == 0);
    check_ports("rand");
    tick();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    clear_left = CLEAR_CYCLES;
    model_zero();
    idle();
    set_rd(0, 0);
    reset = 1'b1;
    tick();
    tick();
    check_ports("reset");

    // 1. reset release: ready low for exactly 32 cycles
    reset = 1'b0;
    for (int c = 0; c < CLEAR_CYCLES; c++) begin
      set_rd($urandom_range(0, 31), $urandom_range(0, 31));
      check_ports("init_clear");
      tick();
    end
    check_all("init_zero");

    // 2. basic write on port 0
    idle();
    set_wr(0, 5'd5, 64'hDEAD_BEEF_0000_0001);
    set_rd(5, 6);
    check_ports("basic_bypass");
    tick();
    idle();
    set_rd(5, 6);
    check_ports("basic_read");
    chk("basic_val", read_data[0 +: DW], 64'hDEAD_BEEF_0000_0001);

    // 3. same-address conflict: port 1 wins
    set_wr(0, 5'd7, 64'h11);
    set_wr(1, 5'd7, 64'h22);
    set_rd(7, 7);
    check_ports("conflict_bypass");
    chk("conflict_bypass_val", read_data[DW +: DW], 64'h22);
    tick();
    idle();
    set_rd(7, 5);
    check_ports("conflict_read");
    chk("conflict_val", read_data[0 +: DW], 64'h22);

    // 4. zero register
    set_wr(1, 5'd0, 64'hFF);
    set_rd(0, 7);
    check_ports("zero_same");
    chk("zero_same_val", read_data[0 +: DW], 64'h0);
    tick();
    idle();
    check_ports("zero_next");
    check_all("zero_others");

    // randomized traffic
    for (int c = 0; c < 400; c++) random_cycle();
    idle();
    while (clear_left > 0) begin
      check_ports("drain");
      tick();
    end

    // 5. fill with index, then request a clear
    for (int i = 0; i < DEPTH; i += 2) begin
      idle();
      set_wr(0, i[AW-1:0], DW'(i));
      set_wr(1, i[AW-1:0] + 5'd1, DW'(i + 1));
      tick();
    end
    idle();
    set_rd(3, 31);
    check_ports("fill_chk");
    chk("fill_val", read_data[DW +: DW], 64'd31);
    clear_request = 1'b1;
    tick();
    for (int c = 0; c < CLEAR_CYCLES; c++) begin
      idle();
      if (c == 10) set_wr(0, 5'd9, 64'hBAD0_BAD0);
      set_rd($urandom_range(0, 31), 9);
      check_ports("req_clear");
      tick();
    end
    check_all("req_zero");

    // 6. reset mid-clear
    idle();
    clear_request = 1'b1;
    tick();
    idle();
    for (int c = 0; c < 10; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < CLEAR_CYCLES; c++) begin
      idle();
      if (c == 4) set_wr(1, 5'd12, 64'h1234_5678);
      set_rd(12, $urandom_range(0, 31));
      check_ports("rst_mid");
      tick();
    end
    check_all("rst_mid_zero");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
